// File: rtl/pci_pkg.sv
// Shared PCI control-line definitions: initiator FSM states and active-low level names.
package pci_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    DATA,
    LAST,
    TURN
  } pci_state_e;

  localparam logic ASSERTED   = 1'b0;
  localparam logic DEASSERTED = 1'b1;

endpackage

// File: rtl/pci_master_arb_agent_if.sv
// Local request port plus shared PCI control lines seen by one initiator agent.
interface pci_master_arb_agent_if #(
  parameter int unsigned LEN_W = 8
);

  logic             start;
  logic [LEN_W-1:0] len;
  logic             gnt_n;
  logic             frame_in_n;
  logic             irdy_in_n;
  logic             trdy_n;
  logic             req_n;
  logic             frame_n;
  logic             irdy_n;
  logic             ctl_oe;
  logic             addr_phase;
  logic             data_ack;
  logic             busy;
  logic             done;
  logic             preempted;

  modport master (
    input  start, len, gnt_n, frame_in_n, irdy_in_n, trdy_n,
    output req_n, frame_n, irdy_n, ctl_oe, addr_phase, data_ack, busy, done, preempted
  );

  modport slave (
    output start, len, gnt_n, frame_in_n, irdy_in_n, trdy_n,
    input  req_n, frame_n, irdy_n, ctl_oe, addr_phase, data_ack, busy, done, preempted
  );

endinterface

// File: rtl/pci_lat_timer.sv
// Master latency timer: reload on address phase, count down while bursting, saturate at zero.
module pci_lat_timer #(
  parameter int unsigned LAT_TIMER = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expired
);

  localparam int unsigned CNT_W = (LAT_TIMER < 2) ? 1 : $clog2(LAT_TIMER + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(LAT_TIMER);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/pci_master_arb_agent.sv
// PCI initiator agent: requests the bus, runs FRAME#/IRDY# for an N-phase burst,
// and splits/resumes the burst when the latency timer expires without grant.
module pci_master_arb_agent
  import pci_pkg::*;
#(
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned LAT_TIMER = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pci_master_arb_agent_if.master bus
);

  localparam bit LAT_EN = (LAT_TIMER != 0);

  pci_state_e       r_state;
  pci_state_e       w_next;
  logic [LEN_W-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_req_n;
  logic             r_preempted;

  logic w_accept;
  logic w_frame_n;
  logic w_irdy_n;
  logic w_oe;
  logic w_addr;
  logic w_ack;
  logic w_lat_load;
  logic w_lat_dec;
  logic w_lat_expired;
  logic w_natural;
  logic w_lat_hit;
  logic w_preempt;
  logic w_finish;
  logic w_resume;
  logic w_bus_won;

  pci_lat_timer #(
    .LAT_TIMER(LAT_TIMER)
  ) u_lat_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_lat_load),
    .i_dec    (w_lat_dec),
    .o_expired(w_lat_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_frame_n  = DEASSERTED;
    w_irdy_n   = DEASSERTED;
    w_oe       = 1'b0;
    w_addr     = 1'b0;
    w_lat_load = 1'b0;
    w_lat_dec  = 1'b0;
    w_natural  = 1'b0;
    w_lat_hit  = 1'b0;
    w_preempt  = 1'b0;
    w_finish   = 1'b0;
    w_resume   = 1'b0;
    w_bus_won  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start && (bus.len != '0)) begin
          w_accept = 1'b1;
          w_next   = REQ;
        end
      end
      REQ: begin
        if ((bus.gnt_n == ASSERTED) && (bus.frame_in_n == DEASSERTED) &&
            (bus.irdy_in_n == DEASSERTED)) begin
          w_bus_won = 1'b1;
          w_next    = ADDR;
        end
      end
      ADDR: begin
        w_frame_n  = ASSERTED;
        w_oe       = 1'b1;
        w_addr     = 1'b1;
        w_lat_load = 1'b1;
        w_next     = (r_rem == LEN_W'(1)) ? LAST : DATA;
      end
      DATA: begin
        w_frame_n = ASSERTED;
        w_irdy_n  = ASSERTED;
        w_oe      = 1'b1;
        w_lat_dec = 1'b1;
        w_natural = (r_rem == LEN_W'(2)) && (bus.trdy_n == ASSERTED);
        // Grant loss alone never ends the burst; only an expired timer without grant does.
        w_lat_hit = LAT_EN && w_lat_expired && (bus.gnt_n == DEASSERTED);
        w_preempt = w_lat_hit && !w_natural;
        if (w_natural || w_lat_hit) begin
          w_next = LAST;
        end
      end
      LAST: begin
        w_irdy_n = ASSERTED;
        w_oe     = 1'b1;
        if (bus.trdy_n == ASSERTED) begin
          w_next = TURN;
        end
      end
      TURN: begin
        w_oe = 1'b1;
        if (r_rem == '0) begin
          w_finish = 1'b1;
          w_next   = IDLE;
        end else begin
          w_resume = 1'b1;
          w_next   = REQ;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign w_ack = (w_irdy_n == ASSERTED) && (bus.trdy_n == ASSERTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_req_n     <= DEASSERTED;
      r_preempted <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_rem       <= bus.len;
        r_busy      <= 1'b1;
        r_req_n     <= ASSERTED;
        r_preempted <= 1'b0;
      end else if (w_ack && (r_rem != '0)) begin
        r_rem <= r_rem - LEN_W'(1);
      end
      // Keep REQ# low through the address phase only if more than one phase remains.
      if (w_bus_won) begin
        r_req_n <= (r_rem > LEN_W'(1)) ? ASSERTED : DEASSERTED;
      end
      if ((r_state == DATA) && (w_next == LAST)) begin
        r_req_n <= DEASSERTED;
      end
      if (w_resume) begin
        r_req_n <= ASSERTED;
      end
      if (w_preempt) begin
        r_preempted <= 1'b1;
      end
      if (w_finish) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign bus.req_n      = r_req_n;
  assign bus.frame_n    = w_frame_n;
  assign bus.irdy_n     = w_irdy_n;
  assign bus.ctl_oe     = w_oe;
  assign bus.addr_phase = w_addr;
  assign bus.data_ack   = w_ack;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.preempted  = r_preempted;

endmodule

// File: tb/tb_pci_master_arb_agent.sv
// Directed bench for the PCI initiator agent; expectations are hand-derived cycle tables.
module tb_pci_master_arb_agent;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  pci_master_arb_agent_if #(.LEN_W(8)) bus ();

  pci_master_arb_agent #(
    .LEN_W    (8),
    .LAT_TIMER(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // {req_n, frame_n, irdy_n, ctl_oe, addr_phase, data_ack, done}
  function automatic logic [6:0] obs();
    return {bus.req_n, bus.frame_n, bus.irdy_n, bus.ctl_oe, bus.addr_phase, bus.data_ack, bus.done};
  endfunction

  task automatic test_reset();
    logic [8:0] v;
    logic       oe_seen;
    rst = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.gnt_n = 1'b1;
    bus.frame_in_n = 1'b1; bus.irdy_in_n = 1'b1; bus.trdy_n = 1'b1;
    repeat (3) tick();
    v = {obs(), bus.busy, bus.preempted};
    n_checks++;
    if (v !== 9'b111000000) $display("FAIL reset_values: got %b want %b", v, 9'b111000000);
    else n_pass++;
    rst = 1'b0;
    bus.gnt_n = 1'b0;
    oe_seen = 1'b0;
    repeat (4) begin
      tick();
      if (bus.ctl_oe !== 1'b0 || bus.req_n !== 1'b1) oe_seen = 1'b1;
    end
    n_checks++;
    if (oe_seen !== 1'b0) $display("FAIL parked_grant: got drive=%b want 0", oe_seen);
    else n_pass++;
  endtask

  task automatic test_basic_burst();
    logic [6:0] exp_v [8];
    exp_v = '{7'b0110000, 7'b0011100, 7'b0001010, 7'b0001010,
              7'b0001010, 7'b1101010, 7'b1111000, 7'b1110001};
    bus.gnt_n = 1'b0; bus.trdy_n = 1'b0;
    bus.start = 1'b1; bus.len = 8'd4;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (obs() !== exp_v[k]) $display("FAIL basic_k%0d: got %b want %b", k, obs(), exp_v[k]);
      else n_pass++;
      if (k == 6) begin
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL basic_busy_turn: got %b want 1", bus.busy);
        else n_pass++;
      end
    end
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", bus.busy);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", bus.done);
    else n_pass++;
  endtask

  task automatic test_single_phase();
    logic [6:0] exp_v [5];
    int f_low;
    int i_low;
    exp_v = '{7'b0110000, 7'b1011100, 7'b1101010, 7'b1111000, 7'b1110001};
    f_low = 0; i_low = 0;
    bus.gnt_n = 1'b0; bus.trdy_n = 1'b0;
    bus.start = 1'b1; bus.len = 8'd1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      if (bus.frame_n === 1'b0) f_low++;
      if (bus.irdy_n === 1'b0) i_low++;
      n_checks++;
      if (obs() !== exp_v[k]) $display("FAIL single_k%0d: got %b want %b", k, obs(), exp_v[k]);
      else n_pass++;
    end
    n_checks++;
    if (f_low != 1 || i_low != 1)
      $display("FAIL single_widths: got frame=%0d irdy=%0d want 1 1", f_low, i_low);
    else n_pass++;
    tick();
  endtask

  task automatic test_bus_busy();
    logic bad;
    int   done_k;
    int   k;
    bad = 1'b0;
    bus.gnt_n = 1'b0; bus.trdy_n = 1'b0; bus.frame_in_n = 1'b0;
    bus.start = 1'b1; bus.len = 8'd2;
    tick();
    bus.start = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      tick();
      if (bus.ctl_oe !== 1'b0 || bus.req_n !== 1'b0 || bus.busy !== 1'b1) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) $display("FAIL other_master_hold: got left_req=%b want 0", bad);
    else n_pass++;
    bus.frame_in_n = 1'b1;
    tick();
    n_checks++;
    if (bus.addr_phase !== 1'b1) $display("FAIL first_idle_addr: got %b want 1", bus.addr_phase);
    else n_pass++;
    done_k = -1;
    k = 6;
    while (done_k < 0 && k < 30) begin
      tick();
      k++;
      if (bus.done === 1'b1) done_k = k;
    end
    n_checks++;
    if (done_k != 10) $display("FAIL bus_busy_done_at: got %0d want 10", done_k);
    else n_pass++;
    tick();
  endtask

  task automatic test_preempt();
    int acks;
    int dones;
    int done_k;
    acks = 0; dones = 0; done_k = -1;
    bus.gnt_n = 1'b0; bus.trdy_n = 1'b0;
    bus.start = 1'b1; bus.len = 8'd10;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 3) bus.gnt_n = 1'b1;
      if (bus.data_ack === 1'b1) acks++;
      if (bus.done === 1'b1) begin dones++; done_k = k; end
      if (k == 5) begin
        n_checks++;
        if ({bus.frame_n, bus.irdy_n} !== 2'b00)
          $display("FAIL lat_zero_still_data: got %b want 00", {bus.frame_n, bus.irdy_n});
        else n_pass++;
      end
      if (k == 6) begin
        n_checks++;
        if ({bus.frame_n, bus.irdy_n, bus.preempted} !== 3'b101)
          $display("FAIL preempt_last: got %b want 101", {bus.frame_n, bus.irdy_n, bus.preempted});
        else n_pass++;
      end
      if (k == 8) begin
        n_checks++;
        if ({bus.req_n, bus.ctl_oe, bus.busy} !== 3'b001)
          $display("FAIL rerequest: got %b want 001", {bus.req_n, bus.ctl_oe, bus.busy});
        else n_pass++;
      end
      if (k == 10) begin
        n_checks++;
        if ({bus.addr_phase, bus.ctl_oe} !== 2'b00)
          $display("FAIL wait_regrant: got %b want 00", {bus.addr_phase, bus.ctl_oe});
        else n_pass++;
        bus.gnt_n = 1'b0;
      end
      if (k == 11) begin
        n_checks++;
        if (bus.addr_phase !== 1'b1) $display("FAIL resume_addr: got %b want 1", bus.addr_phase);
        else n_pass++;
      end
    end
    n_checks++;
    if (acks != 10) $display("FAIL preempt_acks: got %0d want 10", acks);
    else n_pass++;
    n_checks++;
    if (dones != 1 || done_k != 18)
      $display("FAIL preempt_done: got count=%0d at=%0d want 1 at 18", dones, done_k);
    else n_pass++;
    n_checks++;
    if (bus.preempted !== 1'b1) $display("FAIL preempt_sticky: got %b want 1", bus.preempted);
    else n_pass++;
  endtask

  task automatic test_wait_states();
    logic tr [5];
    logic ea [5];
    tr = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    ea = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bus.gnt_n = 1'b0; bus.trdy_n = 1'b1;
    bus.start = 1'b1; bus.len = 8'd2;
    tick();
    bus.start = 1'b0;
    n_checks++;
    if (bus.preempted !== 1'b0) $display("FAIL preempt_cleared: got %b want 0", bus.preempted);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.addr_phase, bus.data_ack} !== 2'b10)
      $display("FAIL ws_addr: got %b want 10", {bus.addr_phase, bus.data_ack});
    else n_pass++;
    for (int j = 0; j < 5; j++) begin
      tick();
      bus.trdy_n = tr[j];
      #1;
      n_checks++;
      if (bus.data_ack !== ea[j]) $display("FAIL ws_ack%0d: got %b want %b", j, bus.data_ack, ea[j]);
      else n_pass++;
      if (j == 2) begin
        n_checks++;
        if ({bus.frame_n, bus.irdy_n} !== 2'b10)
          $display("FAIL ws_last: got %b want 10", {bus.frame_n, bus.irdy_n});
        else n_pass++;
      end
    end
    bus.trdy_n = 1'b0;
    tick();
    n_checks++;
    if ({bus.ctl_oe, bus.frame_n, bus.irdy_n, bus.done} !== 4'b1110)
      $display("FAIL ws_turn: got %b want 1110", {bus.ctl_oe, bus.frame_n, bus.irdy_n, bus.done});
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.done, bus.busy} !== 2'b10) $display("FAIL ws_done: got %b want 10", {bus.done, bus.busy});
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_and_rejects();
    logic [8:0] v;
    logic       bad;
    bus.gnt_n = 1'b0; bus.trdy_n = 1'b0;
    bus.start = 1'b1; bus.len = 8'd4;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({bus.frame_n, bus.irdy_n} !== 2'b00)
      $display("FAIL rst_pre_data: got %b want 00", {bus.frame_n, bus.irdy_n});
    else n_pass++;
    rst = 1'b1;
    tick();
    v = {obs(), bus.busy, bus.preempted};
    n_checks++;
    if (v !== 9'b111000000) $display("FAIL rst_mid_burst: got %b want 111000000", v);
    else n_pass++;
    rst = 1'b0;
    bus.gnt_n = 1'b1;
    bus.start = 1'b1; bus.len = 8'd3;
    tick();
    bus.start = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      tick();
      if (bus.ctl_oe !== 1'b0 || bus.addr_phase !== 1'b0 || bus.req_n !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) $display("FAIL no_grant_stays_req: got left=%b want 0", bad);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.gnt_n = 1'b0;
    bus.start = 1'b1; bus.len = 8'd0;
    tick();
    bus.start = 1'b0;
    tick();
    n_checks++;
    if ({bus.busy, bus.req_n, bus.ctl_oe} !== 3'b010)
      $display("FAIL len_zero_reject: got %b want 010", {bus.busy, bus.req_n, bus.ctl_oe});
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic_burst();
    test_single_phase();
    test_bus_busy();
    test_preempt();
    test_wait_states();
    test_reset_and_rejects();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
